// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard sequencer: PC source select and FSM states.
// Pure declarations, no logic.
// No flow control.
package hazard_ctrl_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;
    localparam logic [1:0] PCSRC_JR  = 2'b11;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MWAIT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_ctrl_perf_counter.sv
// 32-bit wrapping event counter with synchronous clear.
// Latency: count reflects an increment one Clk edge after inc.
// No backpressure; inc is sampled every cycle.
module perf_counter (
    input  logic        Clk,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge Clk) begin
        if (reset)
            count <= '0;
        else if (inc)
            count <= count + 32'd1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stage write-enables, bubbles/flushes, PC source and perf counters.
// Latency: controls are combinational from inputs and state; state/counters update on Clk.
// Backpressure: memory wait states hold every stage up to EX_MEM and bubble MEM_WB.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 3
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        mem_branch,
    input  logic        mem_zero,
    input  logic        mem_jump,
    input  logic        mem_jr,
    input  logic        mem_memread,
    input  logic        mem_memwrite,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        ex_mem_write,
    output logic        if_id_empty,
    output logic        id_ex_empty,
    output logic        ex_mem_empty,
    output logic        mem_wb_empty,
    output logic [1:0]  pc_src,
    output logic        busy,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    localparam bit HAS_WAIT = (MEM_LAT != 0);
    localparam bit LONG_WAIT = (MEM_LAT >= 2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             memacc;
    logic             redirect;
    logic             loaduse;
    logic             mwstall;
    logic             stall_inc;
    logic             flush_inc;

    assign memacc   = mem_memread | mem_memwrite;
    assign redirect = (mem_branch & mem_zero) | mem_jump | mem_jr;
    assign loaduse  = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    // In RELEASE the access already waited; memacc is ignored so the pipeline advances.
    assign mwstall  = ((state == RUN) && memacc && HAS_WAIT) || (state == MWAIT);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_empty  = 1'b0;
        id_ex_empty  = 1'b0;
        ex_mem_empty = 1'b0;
        mem_wb_empty = 1'b0;
        pc_src       = PCSRC_SEQ;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_empty  = 1'b1;
            id_ex_empty  = 1'b1;
            ex_mem_empty = 1'b1;
            mem_wb_empty = 1'b1;
        end else if (mwstall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_empty = 1'b1;
        end else if (redirect) begin
            pc_src       = mem_jr ? PCSRC_JR : (mem_jump ? PCSRC_J : PCSRC_BR);
            if_id_empty  = 1'b1;
            id_ex_empty  = 1'b1;
            ex_mem_empty = 1'b1;
        end else if (loaduse) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_empty  = 1'b1;
        end
    end

    assign busy      = !reset && (state != RUN);
    assign stall_inc = !reset && !pc_write;
    assign flush_inc = !reset && !mwstall && redirect;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (memacc && HAS_WAIT) begin
                        cnt   <= CNT_W'(MEM_LAT - 1);
                        state <= LONG_WAIT ? MWAIT : RELEASE;
                    end
                end
                MWAIT: begin
                    if (cnt == CNT_W'(1))
                        state <= RELEASE;
                    else
                        cnt <= cnt - CNT_W'(1);
                end
                RELEASE: state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    perf_counter u_stall_cnt (
        .Clk   (Clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_count)
    );

    perf_counter u_flush_cnt (
        .Clk   (Clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MEM_LAT=2): vector table plus multi-cycle sequences.
module tb_hazard_ctrl;

    logic        Clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_memread;
    logic        mem_branch, mem_zero, mem_jump, mem_jr, mem_memread, mem_memwrite;
    logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic        if_id_empty, id_ex_empty, ex_mem_empty, mem_wb_empty;
    logic [1:0]  pc_src;
    logic        busy;
    logic [31:0] stall_count, flush_count;

    always #5 Clk = ~Clk;

    hazard_ctrl #(.MEM_LAT(2), .CNT_W(3)) dut (
        .Clk(Clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt),
        .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_jump(mem_jump), .mem_jr(mem_jr),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .if_id_empty(if_id_empty), .id_ex_empty(id_ex_empty),
        .ex_mem_empty(ex_mem_empty), .mem_wb_empty(mem_wb_empty), .pc_src(pc_src),
        .busy(busy), .stall_count(stall_count), .flush_count(flush_count)
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt;
        logic       uses_rt, exmr;
        logic [4:0] exrt;
        logic       br, zero, jmp, jr, mrd, mwr;
    } in_t;

    typedef struct {
        in_t         i;
        logic [10:0] e;
    } vec_t;

    // {pc_write,if_id_write,id_ex_write,ex_mem_write, if_id_e,id_ex_e,ex_mem_e,mem_wb_e, pc_src, busy}
    localparam logic [10:0] E_DEF  = 11'b1111_0000_00_0;
    localparam logic [10:0] E_LU   = 11'b0011_0100_00_0;
    localparam logic [10:0] E_RST  = 11'b0000_1111_00_0;
    localparam logic [10:0] E_MW0  = 11'b0000_0001_00_0;
    localparam logic [10:0] E_MW1  = 11'b0000_0001_00_1;
    localparam logic [10:0] E_REL  = 11'b1111_0000_00_1;
    localparam logic [10:0] E_BR   = 11'b1111_1110_01_0;
    localparam logic [10:0] E_J    = 11'b1111_1110_10_0;
    localparam logic [10:0] E_JR   = 11'b1111_1110_11_0;
    localparam logic [10:0] E_RELJ = 11'b1111_1110_10_1;

    logic [10:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_stall, m_flush;
    bit          cnt_known = 1'b0;

    function automatic in_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                               input logic uses, input logic exmr, input logic [4:0] exrt,
                               input logic br, input logic z, input logic j, input logic jr,
                               input logic mrd, input logic mwr);
        in_t r;
        r.rst = rst; r.rs = rs; r.rt = rt; r.uses_rt = uses; r.exmr = exmr; r.exrt = exrt;
        r.br = br; r.zero = z; r.jmp = j; r.jr = jr; r.mrd = mrd; r.mwr = mwr;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Drive one cycle, queue its expectation, then pop and compare before the next edge.
    task automatic step(input string name, input in_t i, input logic [10:0] e);
        logic [10:0] got, want;
        @(posedge Clk);
        #1;
        reset = i.rst; id_rs = i.rs; id_rt = i.rt; id_uses_rt = i.uses_rt;
        ex_memread = i.exmr; ex_rt = i.exrt; mem_branch = i.br; mem_zero = i.zero;
        mem_jump = i.jmp; mem_jr = i.jr; mem_memread = i.mrd; mem_memwrite = i.mwr;
        exp_q.push_back(e);
        @(negedge Clk);
        got = {pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_empty, id_ex_empty, ex_mem_empty, mem_wb_empty, pc_src, busy};
        want = exp_q.pop_front();
        check({name, " ctl"}, {21'd0, got}, {21'd0, want});
        if (cnt_known) begin
            check({name, " stall_count"}, stall_count, m_stall);
            check({name, " flush_count"}, flush_count, m_flush);
        end
        if (i.rst) begin
            m_stall = '0; m_flush = '0; cnt_known = 1'b1;
        end else begin
            m_stall = m_stall + {31'd0, ~want[10]};
            m_flush = m_flush + {31'd0, want[6]};
        end
    endtask

    vec_t tbl[12];
    in_t  idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = '{mk(0, 5'd3, 5'd4, 1, 0, 5'd0, 0, 0, 0, 0, 0, 0), E_DEF};
        tbl[1]  = '{mk(0, 5'd8, 5'd2, 0, 1, 5'd8, 0, 0, 0, 0, 0, 0), E_LU};
        tbl[2]  = '{mk(0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0, 0, 0), E_DEF};
        tbl[3]  = '{mk(0, 5'd3, 5'd9, 1, 1, 5'd9, 0, 0, 0, 0, 0, 0), E_LU};
        tbl[4]  = '{mk(0, 5'd3, 5'd9, 0, 1, 5'd9, 0, 0, 0, 0, 0, 0), E_DEF};
        tbl[5]  = '{mk(0, 5'd8, 5'd2, 1, 0, 5'd8, 0, 0, 0, 0, 0, 0), E_DEF};
        tbl[6]  = '{mk(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 0, 0, 0, 0), E_BR};
        tbl[7]  = '{mk(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0, 0, 0, 0), E_DEF};
        tbl[8]  = '{mk(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1, 0, 0, 0), E_J};
        tbl[9]  = '{mk(0, 5'd8, 5'd2, 0, 1, 5'd8, 0, 0, 0, 1, 0, 0), E_JR};
        tbl[10] = '{mk(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1, 1, 0, 0), E_JR};
        tbl[11] = '{mk(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 1, 0, 0, 0), E_J};

        reset = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_memread = 1'b0; ex_rt = '0;
        mem_branch = 1'b0; mem_zero = 1'b0; mem_jump = 1'b0; mem_jr = 1'b0;
        mem_memread = 1'b0; mem_memwrite = 1'b0;

        step("reset0", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E_RST);
        step("reset1", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E_RST);
        step("post_reset", idle, E_DEF);

        for (int k = 0; k < 12; k++) begin
            step($sformatf("vec%0d", k), tbl[k].i, tbl[k].e);
            step($sformatf("vec%0d_idle", k), idle, E_DEF);
        end

        // Two wait states, then RELEASE advances even with memread still high.
        step("mw_c1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), E_MW0);
        step("mw_c2", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), E_MW1);
        step("mw_rel", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), E_REL);
        step("mw_done", idle, E_DEF);

        // Store with a jump: the wait state beats the redirect, which lands in RELEASE.
        step("mwj_c1", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), E_MW0);
        step("mwj_c2", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), E_MW1);
        step("mwj_rel", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), E_RELJ);
        step("mwj_done", idle, E_DEF);

        // Reset while waiting abandons the access.
        step("rmw_c1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), E_MW0);
        step("rmw_rst", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), E_RST);
        step("rmw_after", idle, E_DEF);
        step("rmw_after2", idle, E_DEF);

        // Stall counter wrap from all-ones.
        force dut.u_stall_cnt.count = 32'hFFFF_FFFF;
        #1;
        release dut.u_stall_cnt.count;
        m_stall = 32'hFFFF_FFFF;
        step("wrap_stall", tbl[1].i, E_LU);
        step("wrap_after", idle, E_DEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core. It generates the write-enable (hold) and EMPTY (bubble/flush) controls for PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Detects load-use hazards in ID.
- Resolves redirects (branch/jump/jr) in MEM.
- Inserts wait states for a multi-cycle data memory.
- Keeps stall/flush performance counters.

Parameters:
MEM_LAT, 2, extra stall cycles per data-memory access (0 = single-cycle memory, no wait states)
CNT_W, 3, width of wait-state counter (must hold MEM_LAT)

Ports:
Clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_memread  in  1  memread of instruction in EX (ID_EX output)
ex_rt  in  5  destination rt of the load in EX
mem_branch  in  1  branch flag at EX_MEM output
mem_zero  in  1  zero flag at EX_MEM output
mem_jump  in  1  jump flag at EX_MEM output
mem_jr  in  1  jr flag at EX_MEM output
mem_memread  in  1  memread at EX_MEM output
mem_memwrite  in  1  memwrite at EX_MEM output
pc_write  out  1  PC update enable
if_id_write  out  1  IF_ID load enable
id_ex_write  out  1  ID_EX load enable
ex_mem_write  out  1  EX_MEM load enable
if_id_empty  out  1  IF_ID bubble/flush
id_ex_empty  out  1  ID_EX bubble/flush
ex_mem_empty  out  1  EX_MEM bubble/flush
mem_wb_empty  out  1  MEM_WB bubble
pc_src  out  2  00 pc+4, 01 branch target, 10 jump target, 11 register (jr)
busy  out  1  state != RUN
stall_count  out  32  cycles with pc_write=0, wraps
flush_count  out  32  redirects taken, wraps

Behaviour:
- Reset (sync, Clk edge with reset=1):
  - Registered state: state=RUN, cnt=0, stall_count=0, flush_count=0.
  - While reset=1, combinational outputs are forced: all *_write=0, all *_empty=1, pc_src=00, busy=0.
- Defaults, no event: all *_write=1, all *_empty=0, pc_src=00.
- Signal definitions:
  - memacc = mem_memread | mem_memwrite
  - redirect = (mem_branch & mem_zero) | mem_jump | mem_jr
  - loaduse = ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt))
- States: RUN, MWAIT, RELEASE.
- Memory wait stall (mwstall):
  - Asserted when (RUN & memacc & MEM_LAT!=0) or state==MWAIT.
  - Outputs: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_write=0, mem_wb_empty=1. Other *_empty=0.
- Transitions:
  - RUN, memacc, MEM_LAT!=0: cnt<=MEM_LAT-1; next MWAIT if MEM_LAT>=2, else RELEASE.
  - MWAIT: if cnt==1, next RELEASE; else cnt<=cnt-1.
  - RELEASE: memacc ignored for this cycle, pipeline advances, next RUN.
  - Total stall cycles per access = MEM_LAT.
  - MEM_LAT=0: never leaves RUN.
- Priority per cycle: reset > mwstall > redirect > loaduse.
  - redirect and loaduse are evaluated in RUN and RELEASE only.
- Redirect:
  - pc_src = 11 if mem_jr, else 10 if mem_jump, else 01.
  - pc_write=1.
  - if_id_empty=1, id_ex_empty=1, ex_mem_empty=1.
  - Load-use is suppressed in a redirect cycle (the ID instruction is being flushed).
  - flush_count+1.
- Load-use stall (one cycle):
  - pc_write=0, if_id_write=0, id_ex_empty=1.
  - ex_mem proceeds normally.
  - Next cycle the load is in MEM, so loaduse deasserts naturally.
- Counters:
  - stall_count+1 on every non-reset cycle with pc_write=0.
  - Both counters wrap 0xFFFFFFFF -> 0.
- Reset mid-MWAIT: returns to RUN next edge; the pending access is not resumed.

Decomposition:
- Shared package: pc_src encodings (PCSRC_SEQ/BR/J/JR) and state encodings (RUN/MWAIT/RELEASE).
- One natural sub-module: perf_counter (32-bit, sync reset, inc enable), instantiated twice.

Test Plan:
- reset=1 for 2 cycles -> all *_empty=1, all *_write=0; after release stall_count=0, flush_count=0, busy=0.
- ex_memread=1, ex_rt=8, id_rs=8 -> exactly one cycle pc_write=0, if_id_write=0, id_ex_empty=1; stall_count=1. Repeat with ex_rt=0 -> no stall.
- MEM_LAT=2, mem_memread=1 held 3 cycles -> stall on cycles 1-2 (busy=1 on cycle 2), mem_wb_empty=1 on both; cycle 3 in RELEASE advances; stall_count=2.
- mem_branch=1, mem_zero=1 -> pc_src=01, if_id_empty/id_ex_empty/ex_mem_empty=1, flush_count=1.
- mem_jr=1 together with loaduse=1 -> pc_src=11, flush asserted, pc_write=1, no stall counted.
- Reset asserted during MWAIT (cnt=1) -> next cycle state=RUN, busy=0; counters cleared.
- Preload stall_count=0xFFFFFFFF via forced stall -> wraps to 0.
